// File: rtl/xas_pkg.sv
// rtl/xas_pkg.sv - shared types, defaults and helpers for the xor_and_scheduler slice
package xas_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } xas_state_t;

   localparam int NREQ_DEF = 4;
   localparam int W_DEF    = 4;
   localparam int CNTW_DEF = 16;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
// Searches ptr, ptr+1, ... modulo NREQ and grants the first active request.
module rr_arbiter
   import xas_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IDW  = clog2(NREQ_DEF)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx
);

   logic [IDW:0]   w_sum;
   logic [IDW-1:0] w_cand;
   logic           w_found;

   always_comb begin
      gnt     = '0;
      idx     = '0;
      w_sum   = '0;
      w_cand  = '0;
      w_found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         // ptr is always below NREQ, so one wrap subtraction is enough
         w_sum = {1'b0, ptr} + (IDW+1)'(k);
         if (w_sum >= (IDW+1)'(NREQ)) w_sum = w_sum - (IDW+1)'(NREQ);
         w_cand = w_sum[IDW-1:0];
         if (en && !w_found && req[w_cand]) begin
            w_found     = 1'b1;
            gnt[w_cand] = 1'b1;
            idx         = w_cand;
         end
      end
   end

endmodule

// File: rtl/xor_and_scheduler.sv
// rtl/xor_and_scheduler.sv - round-robin sharing of one registered (A^B)&C stage
// Holds one result until accepted; a new grant may replace it in the accept cycle.
module xor_and_scheduler
   import xas_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int W    = W_DEF,
   parameter int IDW  = clog2(NREQ_DEF),
   parameter int CNTW = CNTW_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   input  logic [NREQ*W-1:0] req_c,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [W-1:0]      rsp_a,
   output logic [W-1:0]      rsp_b,
   output logic [W-1:0]      rsp_and,
   output logic [CNTW-1:0]   ops_done
);

   xas_state_t      r_state;
   logic [IDW-1:0]  r_ptr;
   logic [IDW-1:0]  r_id;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [W-1:0]    r_and;
   logic [CNTW-1:0] r_ops;

   logic            w_can_issue;
   logic            w_fire;
   logic            w_accept;
   logic [NREQ-1:0] w_gnt;
   logic [IDW-1:0]  w_idx;
   logic [W-1:0]    w_a;
   logic [W-1:0]    w_b;
   logic [W-1:0]    w_c;
   logic [IDW:0]    w_ptr_inc;
   logic [IDW-1:0]  w_ptr_nxt;

   // Reset gates the arbiter so no requester sees ready while reset is high
   assign w_can_issue = !reset && ((r_state == IDLE) || (r_state == HOLD && rsp_ready));
   assign w_accept    = (r_state == HOLD) && rsp_ready;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req (req_valid),
      .ptr (r_ptr),
      .en  (w_can_issue),
      .gnt (w_gnt),
      .idx (w_idx)
   );

   assign w_fire = |w_gnt;
   assign w_a    = req_a[w_idx*W +: W];
   assign w_b    = req_b[w_idx*W +: W];
   assign w_c    = req_c[w_idx*W +: W];

   assign w_ptr_inc = {1'b0, w_idx} + (IDW+1)'(1);
   assign w_ptr_nxt = (w_ptr_inc >= (IDW+1)'(NREQ)) ? '0 : w_ptr_inc[IDW-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_id    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_and   <= '0;
         r_ops   <= '0;
      end else begin
         if (w_fire) begin
            r_id    <= w_idx;
            r_a     <= w_a;
            r_b     <= w_b;
            r_and   <= (w_a ^ w_b) & w_c;
            r_ptr   <= w_ptr_nxt;
            r_state <= HOLD;
         end else if (w_accept) begin
            r_state <= IDLE;
         end
         if (w_accept && (r_ops != {CNTW{1'b1}})) begin
            r_ops <= r_ops + CNTW'(1);
         end
      end
   end

   assign req_ready = w_gnt;
   assign rsp_valid = (r_state == HOLD);
   assign rsp_id    = r_id;
   assign rsp_a     = r_a;
   assign rsp_b     = r_b;
   assign rsp_and   = r_and;
   assign ops_done  = r_ops;

endmodule

// File: doc/xor_and_scheduler.md
Name: xor_and_scheduler

Overview:
- Shares a single registered XOR-AND compute stage, ANDo = (A ^ B) & C with A/B pass-through, between NREQ requesters.
- Each requester presents a 4-bit A/B/C operand triple on a valid/ready handshake.
- A round-robin arbiter grants one requester, latches its operands into the stage, and returns the result with the winner's ID on a single valid/ready response port.
- Sits between the nonce-mixing clients and the shared logic slice in the mining datapath.

Parameters:
- NREQ, 4, number of requesters; 2..8.
- W, 4, operand and result width.
- IDW, 2, requester ID width; must equal clog2(NREQ).
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester grant/accept; at most one bit high (one-hot or zero).
- req_a  input  NREQ*W  operand A; requester i occupies bits [i*W +: W].
- req_b  input  NREQ*W  operand B; same packing.
- req_c  input  NREQ*W  operand C; same packing.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  downstream accepts result.
- rsp_id  output  IDW  index of the requester that owns the result.
- rsp_a  output  W  latched A.
- rsp_b  output  W  latched B.
- rsp_and  output  W  (A ^ B) & C.
- ops_done  output  CNTW  count of completed responses; saturates at all-ones.

Behaviour:
- Reset (synchronous, sampled on clk rising edge while reset=1):
  - state=IDLE, rr_ptr=0.
  - rsp_valid=0, rsp_id=0, rsp_a=0, rsp_b=0, rsp_and=0, ops_done=0.
  - req_ready=0 during reset.
- Reset asserted mid-operation drops any pending result; it is never re-presented.
- States:
  - IDLE: no result held.
  - HOLD: rsp_valid=1; result registers stable until accepted.
- Grant enable: `can_issue` = (state==IDLE) OR (state==HOLD AND rsp_ready).
- Winner selection (combinational):
  - When can_issue is true, the winner is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[winner]=1; all other req_ready bits are 0.
  - req_ready never depends on req_valid of the same requester beyond this selection.
- Issue, at the edge where req_valid[w] & req_ready[w]:
  - Latch rsp_a=A_w, rsp_b=B_w, rsp_and=(A_w^B_w)&C_w, rsp_id=w.
  - rr_ptr <= (w+1) mod NREQ; state <= HOLD.
- Latency: the result is visible with rsp_valid=1 one cycle after the grant edge.
- Response:
  - In HOLD with rsp_ready=1, the response completes and ops_done increments, saturating at 2^CNTW-1.
  - If a new grant occurs in the same cycle, state stays HOLD with new contents (back-to-back, one result per cycle). Otherwise state <= IDLE and rsp_valid <= 0.
- In HOLD with rsp_ready=0:
  - All req_ready=0.
  - Outputs hold exactly (no change in rsp_id/rsp_a/rsp_b/rsp_and).
  - rr_ptr holds.
- No valid requesters: no grant; rr_ptr unchanged.
- req_valid deasserted without a grant is legal; nothing is latched.
- Requesters must hold operands stable while valid until accepted. The block samples only on grant.
- Arithmetic is bitwise and width-preserving; no carries.

Decomposition:
- Shared package xas_pkg:
  - State encoding typedef: IDLE=1'b0, HOLD=1'b1.
  - Localparams NREQ_DEF=4, W_DEF=4, CNTW_DEF=16.
  - Function clog2.
- One natural sub-module, rr_arbiter (inputs NREQ req, ptr, en; outputs one-hot gnt and encoded idx).
- The datapath latch and XOR-AND stay in the top module.

Test Plan:
- Reset check: hold reset 3 cycles with req_valid=4'b1111 -> req_ready=0, rsp_valid=0, ops_done=0 throughout. Then, 1 cycle after release, req_ready=4'b0001.
- Single request: req 2 with A=4'hA, B=4'h5, C=4'h6, rsp_ready=1 -> req_ready=4'b0100 in cycle t. In cycle t+1, rsp_valid=1, rsp_id=2, rsp_a=A, rsp_b=5, rsp_and=4'h6. ops_done=1 after acceptance.
- Round robin: all four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0. One rsp_valid per cycle after the first.
- Backpressure: rsp_ready=0 for 5 cycles while req 1,3 valid -> rsp outputs frozen and req_ready=0. When rsp_ready=1, the next grant goes to the next index after the last winner.
- Mid-op reset: assert reset in HOLD with rsp_valid=1 -> next cycle rsp_valid=0, rsp_* =0. The old result never reappears.
- Saturation: use CNTW=4 and complete 20 ops -> ops_done sticks at 15.
